// File: rtl/mem_access_stage.sv
// mem_access_stage
//   Memory stage between execute and writeback. Non-memory instructions pass
//   through in one cycle. Word loads and stores are issued to a multi-cycle
//   data memory over a req/ack handshake. While an access is outstanding,
//   upstream is stalled. Misaligned accesses and accesses that time out
//   retire with out_err set.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid, aluOut,          instruction from execute; aluOut is the address
//   read2Data, memRead,        for memory ops, or the value forwarded otherwise
//   memWrite
//   stall                      hold upstream (combinational)
//   mem_req, mem_wr,           memory request channel, held stable while mem_req
//   mem_addr, mem_wdata
//   mem_rdata, mem_ack         memory response
//   out_valid, out_alu,        registered result to writeback
//   out_rdata, out_err
//
// FSM states
//   state  | meaning
//   IDLE   | accepting a new instruction; non-memory ops retire from here
//   REQ    | memory request outstanding, waiting for ack or timeout
module mem_access_stage #(
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] aluOut,
   input  logic [DATA_W-1:0] read2Data,
   input  logic              memRead,
   input  logic              memWrite,
   output logic              stall,
   output logic              mem_req,
   output logic              mem_wr,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_alu,
   output logic [DATA_W-1:0] out_rdata,
   output logic              out_err
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_REQ  = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0]  addr_q, addr_d;
   logic [DATA_W-1:0]  wdata_q, wdata_d;
   logic               wr_q, wr_d;
   logic               out_valid_q, out_valid_d;
   logic [DATA_W-1:0]  out_alu_q, out_alu_d;
   logic [DATA_W-1:0]  out_rdata_q, out_rdata_d;
   logic               out_err_q, out_err_d;

   logic memop;
   logic mis;
   logic timeout_hit;

   assign memop       = in_valid & (memRead | memWrite);
   assign mis         = memop & aluOut[0];
   assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wr_q        <= 1'b0;
         out_valid_q <= 1'b0;
         out_alu_q   <= '0;
         out_rdata_q <= '0;
         out_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wr_q        <= wr_d;
         out_valid_q <= out_valid_d;
         out_alu_q   <= out_alu_d;
         out_rdata_q <= out_rdata_d;
         out_err_q   <= out_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wr_d        = wr_q;
      out_valid_d = 1'b0;
      out_alu_d   = out_alu_q;
      out_rdata_d = out_rdata_q;
      out_err_d   = out_err_q;
      stall       = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (memop && !mis) begin
               state_d = S_REQ;
               addr_d  = aluOut;
               wdata_d = read2Data;
               wr_d    = memWrite;
               cnt_d   = '0;
               stall   = 1'b1;
            end else if (mis) begin
               out_valid_d = 1'b1;
               out_alu_d   = aluOut;
               out_rdata_d = '0;
               out_err_d   = 1'b1;
            end else if (in_valid) begin
               out_valid_d = 1'b1;
               out_alu_d   = aluOut;
               out_rdata_d = '0;
               out_err_d   = 1'b0;
            end
         end
         S_REQ: begin
            if (mem_ack) begin
               state_d     = S_IDLE;
               out_valid_d = 1'b1;
               out_alu_d   = addr_q;
               out_rdata_d = wr_q ? '0 : mem_rdata;
               out_err_d   = 1'b0;
            end else if (timeout_hit) begin
               // Abort: the memory may still ack later; that ack lands in IDLE and is ignored.
               state_d     = S_IDLE;
               out_valid_d = 1'b1;
               out_alu_d   = addr_q;
               out_rdata_d = '0;
               out_err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               stall = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign mem_req   = (state_q == S_REQ);
   assign mem_wr    = wr_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign out_valid = out_valid_q;
   assign out_alu   = out_alu_q;
   assign out_rdata = out_rdata_q;
   assign out_err   = out_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed testbench for mem_access_stage. Inputs change on the falling edge;
// combinational outputs are sampled 1 ns after that, registered outputs 1 ns
// after the rising edge.
module tb_mem_access_stage;

   localparam int DATA_W  = 16;
   localparam int TIMEOUT = 16;
   localparam int CNT_W   = 5;

   logic              clk;
   logic              rst_n;
   logic              in_valid;
   logic [DATA_W-1:0] aluOut;
   logic [DATA_W-1:0] read2Data;
   logic              memRead;
   logic              memWrite;
   logic              stall;
   logic              mem_req;
   logic              mem_wr;
   logic [DATA_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;
   logic              out_valid;
   logic [DATA_W-1:0] out_alu;
   logic [DATA_W-1:0] out_rdata;
   logic              out_err;

   int checks   = 0;
   int failures = 0;

   mem_access_stage #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .aluOut    (aluOut),
      .read2Data (read2Data),
      .memRead   (memRead),
      .memWrite  (memWrite),
      .stall     (stall),
      .mem_req   (mem_req),
      .mem_wr    (mem_wr),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack),
      .out_valid (out_valid),
      .out_alu   (out_alu),
      .out_rdata (out_rdata),
      .out_err   (out_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic drive_idle();
      in_valid  = 1'b0;
      aluOut    = '0;
      read2Data = '0;
      memRead   = 1'b0;
      memWrite  = 1'b0;
      mem_ack   = 1'b0;
      mem_rdata = '0;
   endtask

   task automatic after_rise();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive_idle();
      #12;
      checks++; if (mem_req !== 1'b0)   begin failures++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
      checks++; if (mem_wr !== 1'b0)    begin failures++; $display("FAIL reset_mem_wr got %b exp 0", mem_wr); end
      checks++; if (mem_addr !== 16'h0) begin failures++; $display("FAIL reset_mem_addr got %h exp 0000", mem_addr); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      checks++; if (out_err !== 1'b0)   begin failures++; $display("FAIL reset_out_err got %b exp 0", out_err); end
      checks++; if (out_alu !== 16'h0)  begin failures++; $display("FAIL reset_out_alu got %h exp 0000", out_alu); end
      checks++; if (out_rdata !== 16'h0) begin failures++; $display("FAIL reset_out_rdata got %h exp 0000", out_rdata); end
      checks++; if (stall !== 1'b0)     begin failures++; $display("FAIL reset_stall got %b exp 0", stall); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_alu_op();
      @(negedge clk);
      in_valid = 1'b1; aluOut = 16'h1234;
      #1;
      checks++; if (stall !== 1'b0)   begin failures++; $display("FAIL alu_stall got %b exp 0", stall); end
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL alu_mem_req got %b exp 0", mem_req); end
      after_rise();
      checks++; if (out_valid !== 1'b1)  begin failures++; $display("FAIL alu_out_valid got %b exp 1", out_valid); end
      checks++; if (out_alu !== 16'h1234) begin failures++; $display("FAIL alu_out_alu got %h exp 1234", out_alu); end
      checks++; if (out_rdata !== 16'h0) begin failures++; $display("FAIL alu_out_rdata got %h exp 0000", out_rdata); end
      checks++; if (out_err !== 1'b0)    begin failures++; $display("FAIL alu_out_err got %b exp 0", out_err); end
      @(negedge clk);
      drive_idle();
      after_rise();
      checks++; if (out_valid !== 1'b0)   begin failures++; $display("FAIL alu_pulse got %b exp 0", out_valid); end
      checks++; if (out_alu !== 16'h1234) begin failures++; $display("FAIL alu_hold got %h exp 1234", out_alu); end
   endtask

   task automatic test_load_ack3();
      int stall_cycles;
      stall_cycles = 0;
      @(negedge clk);
      in_valid = 1'b1; aluOut = 16'h0040; memRead = 1'b1; read2Data = 16'h7777;
      #1;
      if (stall === 1'b1) stall_cycles++;
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL load_idle_req got %b exp 0", mem_req); end
      for (int i = 1; i <= 3; i++) begin
         after_rise();
         checks++; if (mem_req !== 1'b1)     begin failures++; $display("FAIL load_req%0d got %b exp 1", i, mem_req); end
         checks++; if (mem_addr !== 16'h0040) begin failures++; $display("FAIL load_addr%0d got %h exp 0040", i, mem_addr); end
         checks++; if (mem_wr !== 1'b0)      begin failures++; $display("FAIL load_wr%0d got %b exp 0", i, mem_wr); end
         checks++; if (out_valid !== 1'b0)   begin failures++; $display("FAIL load_busy_valid%0d got %b exp 0", i, out_valid); end
         @(negedge clk);
         if (i == 3) begin mem_ack = 1'b1; mem_rdata = 16'hBEEF; end
         #1;
         if (stall === 1'b1) stall_cycles++;
      end
      checks++; if (stall_cycles != 3) begin failures++; $display("FAIL load_stall_cycles got %0d exp 3", stall_cycles); end
      after_rise();
      checks++; if (out_valid !== 1'b1)    begin failures++; $display("FAIL load_out_valid got %b exp 1", out_valid); end
      checks++; if (out_rdata !== 16'hBEEF) begin failures++; $display("FAIL load_out_rdata got %h exp beef", out_rdata); end
      checks++; if (out_err !== 1'b0)      begin failures++; $display("FAIL load_out_err got %b exp 0", out_err); end
      checks++; if (out_alu !== 16'h0040)  begin failures++; $display("FAIL load_out_alu got %h exp 0040", out_alu); end
      checks++; if (mem_req !== 1'b0)      begin failures++; $display("FAIL load_req_drop got %b exp 0", mem_req); end
      @(negedge clk);
      drive_idle();
   endtask

   task automatic test_store_ack1();
      @(negedge clk);
      in_valid = 1'b1; aluOut = 16'h0010; read2Data = 16'hA5A5; memWrite = 1'b1;
      #1;
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL store_idle_stall got %b exp 1", stall); end
      after_rise();
      checks++; if (mem_req !== 1'b1)       begin failures++; $display("FAIL store_req got %b exp 1", mem_req); end
      checks++; if (mem_wr !== 1'b1)        begin failures++; $display("FAIL store_wr got %b exp 1", mem_wr); end
      checks++; if (mem_wdata !== 16'hA5A5) begin failures++; $display("FAIL store_wdata got %h exp a5a5", mem_wdata); end
      checks++; if (mem_addr !== 16'h0010)  begin failures++; $display("FAIL store_addr got %h exp 0010", mem_addr); end
      @(negedge clk);
      mem_ack = 1'b1; mem_rdata = 16'h5555;
      #1;
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL store_ack_stall got %b exp 0", stall); end
      after_rise();
      checks++; if (out_valid !== 1'b1)  begin failures++; $display("FAIL store_out_valid got %b exp 1", out_valid); end
      checks++; if (out_rdata !== 16'h0) begin failures++; $display("FAIL store_out_rdata got %h exp 0000", out_rdata); end
      checks++; if (mem_req !== 1'b0)    begin failures++; $display("FAIL store_req_drop got %b exp 0", mem_req); end
      @(negedge clk);
      drive_idle();
   endtask

   task automatic test_misaligned();
      @(negedge clk);
      in_valid = 1'b1; aluOut = 16'h0003; memRead = 1'b1;
      #1;
      checks++; if (stall !== 1'b0)   begin failures++; $display("FAIL mis_stall got %b exp 0", stall); end
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL mis_req got %b exp 0", mem_req); end
      after_rise();
      checks++; if (mem_req !== 1'b0)    begin failures++; $display("FAIL mis_req_after got %b exp 0", mem_req); end
      checks++; if (out_valid !== 1'b1)  begin failures++; $display("FAIL mis_out_valid got %b exp 1", out_valid); end
      checks++; if (out_err !== 1'b1)    begin failures++; $display("FAIL mis_out_err got %b exp 1", out_err); end
      checks++; if (out_rdata !== 16'h0) begin failures++; $display("FAIL mis_out_rdata got %h exp 0000", out_rdata); end
      @(negedge clk);
      drive_idle();
   endtask

   task automatic test_timeout();
      int req_cycles;
      req_cycles = 0;
      @(negedge clk);
      in_valid = 1'b1; aluOut = 16'h0080; memRead = 1'b1;
      for (int i = 1; i <= TIMEOUT; i++) begin
         after_rise();
         if (mem_req === 1'b1) req_cycles++;
         checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL to_busy_valid%0d got %b exp 0", i, out_valid); end
      end
      checks++; if (req_cycles != TIMEOUT) begin failures++; $display("FAIL to_req_cycles got %0d exp %0d", req_cycles, TIMEOUT); end
      @(negedge clk); #1;
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL to_last_stall got %b exp 0", stall); end
      after_rise();
      checks++; if (mem_req !== 1'b0)    begin failures++; $display("FAIL to_req_drop got %b exp 0", mem_req); end
      checks++; if (out_valid !== 1'b1)  begin failures++; $display("FAIL to_out_valid got %b exp 1", out_valid); end
      checks++; if (out_err !== 1'b1)    begin failures++; $display("FAIL to_out_err got %b exp 1", out_err); end
      checks++; if (out_rdata !== 16'h0) begin failures++; $display("FAIL to_out_rdata got %h exp 0000", out_rdata); end
      @(negedge clk);
      drive_idle();
      @(negedge clk);
      mem_ack = 1'b1; mem_rdata = 16'hDEAD;
      after_rise();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL to_stray_valid got %b exp 0", out_valid); end
      checks++; if (mem_req !== 1'b0)   begin failures++; $display("FAIL to_stray_req got %b exp 0", mem_req); end
      @(negedge clk);
      drive_idle();
   endtask

   task automatic test_reset_mid_access();
      @(negedge clk);
      in_valid = 1'b1; aluOut = 16'h0060; memRead = 1'b1;
      after_rise();
      after_rise();
      checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL rst_mid_pre_req got %b exp 1", mem_req); end
      @(negedge clk);
      rst_n = 1'b0;
      drive_idle();
      #1;
      checks++; if (mem_req !== 1'b0)   begin failures++; $display("FAIL rst_mid_req got %b exp 0", mem_req); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got %b exp 0", out_valid); end
      checks++; if (stall !== 1'b0)     begin failures++; $display("FAIL rst_mid_stall got %b exp 0", stall); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      in_valid = 1'b1; aluOut = 16'h0100; memRead = 1'b1;
      after_rise();
      checks++; if (mem_addr !== 16'h0100) begin failures++; $display("FAIL rst_post_addr got %h exp 0100", mem_addr); end
      @(negedge clk);
      mem_ack = 1'b1; mem_rdata = 16'h1357;
      after_rise();
      checks++; if (out_valid !== 1'b1)    begin failures++; $display("FAIL rst_post_valid got %b exp 1", out_valid); end
      checks++; if (out_rdata !== 16'h1357) begin failures++; $display("FAIL rst_post_rdata got %h exp 1357", out_rdata); end
      checks++; if (out_err !== 1'b0)      begin failures++; $display("FAIL rst_post_err got %b exp 0", out_err); end
      @(negedge clk);
      drive_idle();
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      in_valid = 1'b1; aluOut = 16'h0200; memRead = 1'b1;
      after_rise();
      @(negedge clk);
      mem_ack = 1'b1; mem_rdata = 16'h1111;
      after_rise();
      checks++; if (out_rdata !== 16'h1111) begin failures++; $display("FAIL b2b_first_rdata got %h exp 1111", out_rdata); end
      @(negedge clk);
      mem_ack = 1'b0; memRead = 1'b0; memWrite = 1'b1; aluOut = 16'h0202; read2Data = 16'h2222;
      #1;
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL b2b_accept_stall got %b exp 1", stall); end
      after_rise();
      checks++; if (mem_req !== 1'b1)       begin failures++; $display("FAIL b2b_req got %b exp 1", mem_req); end
      checks++; if (mem_addr !== 16'h0202)  begin failures++; $display("FAIL b2b_addr got %h exp 0202", mem_addr); end
      checks++; if (mem_wr !== 1'b1)        begin failures++; $display("FAIL b2b_wr got %b exp 1", mem_wr); end
      checks++; if (mem_wdata !== 16'h2222) begin failures++; $display("FAIL b2b_wdata got %h exp 2222", mem_wdata); end
      checks++; if (out_valid !== 1'b0)     begin failures++; $display("FAIL b2b_busy_valid got %b exp 0", out_valid); end
      @(negedge clk);
      mem_ack = 1'b1;
      after_rise();
      checks++; if (out_valid !== 1'b1)  begin failures++; $display("FAIL b2b_second_valid got %b exp 1", out_valid); end
      checks++; if (out_rdata !== 16'h0) begin failures++; $display("FAIL b2b_second_rdata got %h exp 0000", out_rdata); end
      checks++; if (out_alu !== 16'h0202) begin failures++; $display("FAIL b2b_second_alu got %h exp 0202", out_alu); end
      @(negedge clk);
      drive_idle();
   endtask

   initial begin
      test_reset();
      test_alu_op();
      test_load_ack3();
      test_store_ack1();
      test_misaligned();
      test_timeout();
      test_reset_mid_access();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
